// File: rtl/mode_arbiter_if.sv
// ---------------------------------------------------------------------------
// mode_arbiter_if
// Handshake bundle between the three write-datapath sources and the mode
// arbiter.
//   req         [2:0] level requests, req[i] from source i+1
//   en_in       [2:0] data strobes en1/en2/en3 (same nets as the mux inputs)
//   mode        [1:0] mux select, 0..2 = source 1..3, 3 = idle (mux outputs 0)
//   gnt         [2:0] one-hot grant
//   busy              arbiter not idle
//   timeout_err       one-cycle pulse on watchdog release
// master modport: the source side; slave modport: the arbiter.
// ---------------------------------------------------------------------------
interface mode_arbiter_if;
    logic [2:0] req;
    logic [2:0] en_in;
    logic [1:0] mode;
    logic [2:0] gnt;
    logic       busy;
    logic       timeout_err;

    modport master (
        output req, en_in,
        input  mode, gnt, busy, timeout_err
    );

    modport slave (
        input  req, en_in,
        output mode, gnt, busy, timeout_err
    );
endinterface

// File: rtl/mode_arbiter.sv
// ---------------------------------------------------------------------------
// mode_arbiter
// Round-robin sequencer for the three-input mode multiplexer on the SSD write
// datapath. A requesting source gets a bounded burst (counted in en strobes);
// mode switches are fenced by a guard cycle before the grant and a drain
// cycle after it, so the multiplexer's one-cycle registered path never loses
// or mis-routes a beat.
//
// Parameters:
//   BURST_LEN  max strobes per grant (>= 1)
//   TIMEOUT    idle-strobe cycles before forced release (>= 2), only used
//              when MODE_ARB_TIMEOUT_EN is defined
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-high reset
//   bus   mode_arbiter_if.slave (req, en_in in; mode, gnt, busy,
//         timeout_err out)
// Build option:
//   MODE_ARB_TIMEOUT_EN  adds the grant watchdog and drives timeout_err;
//                        without it timeout_err is tied to 0.
// ---------------------------------------------------------------------------
module mode_arbiter #(
    parameter int BURST_LEN = 256,
    parameter int TIMEOUT   = 1024
) (
    input  logic            clk,
    input  logic            rst,
    mode_arbiter_if.slave   bus
);

    localparam int CW = $clog2(BURST_LEN + 1);

    if (BURST_LEN < 1 || TIMEOUT < 2) begin : g_param_check
        $error("mode_arbiter: BURST_LEN must be >= 1 and TIMEOUT >= 2");
    end

    typedef enum logic [1:0] {IDLE, SWITCH, GRANT, DRAIN} state_t;

    state_t        state;
    logic [1:0]    idx;      // source owning the current burst
    logic [1:0]    ptr;      // round-robin start point for the next search
    logic [CW-1:0] cnt;      // strobes counted in this burst
    logic [1:0]    mode_q;
    logic [2:0]    gnt_q;
    logic          busy_q;

    logic [1:0]    pick;
    logic [1:0]    p1;
    logic [1:0]    p2;
    logic          strobe;
    logic          burst_end;
    logic          wd_fire;

    function automatic logic [1:0] next_idx(input logic [1:0] i);
        return (i == 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    // Only the granted source's strobe is ever looked at; foreign strobes
    // are ignored in every state.
    assign strobe    = bus.en_in[idx];
    assign burst_end = strobe && (cnt == CW'(BURST_LEN - 1));

    // First requester searching ptr, ptr+1, ptr+2 (mod 3).
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        p1   = next_idx(ptr);
        p2   = next_idx(p1);
        pick = p2;
        if (bus.req[ptr])
            pick = ptr;
        else if (bus.req[p1])
            pick = p1;
    end

`ifdef MODE_ARB_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd;
    logic          terr_q;

    // Fires on the TIMEOUT-th consecutive strobe-less GRANT cycle.
    assign wd_fire         = !strobe && (wd == WW'(TIMEOUT - 1));
    assign bus.timeout_err = terr_q;
`else
    assign wd_fire         = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= 2'd0;
            ptr    <= 2'd0;
            cnt    <= '0;
            mode_q <= 2'd3;
            gnt_q  <= 3'b000;
            busy_q <= 1'b0;
`ifdef MODE_ARB_TIMEOUT_EN
            wd     <= '0;
            terr_q <= 1'b0;
`endif
        end else begin
`ifdef MODE_ARB_TIMEOUT_EN
            terr_q <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (|bus.req) begin
                        idx    <= pick;
                        mode_q <= pick;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= SWITCH;
                    end
                end

                // Guard cycle: mux has already switched, grant follows.
                SWITCH: begin
                    gnt_q <= 3'b001 << idx;
                    state <= GRANT;
`ifdef MODE_ARB_TIMEOUT_EN
                    wd    <= '0;
`endif
                end

                GRANT: begin
                    if (strobe && cnt != CW'(BURST_LEN))
                        cnt <= cnt + 1'b1;
`ifdef MODE_ARB_TIMEOUT_EN
                    wd <= strobe ? '0 : wd + 1'b1;
`endif
                    // A strobe coinciding with req dropping is still counted.
                    if (burst_end || !bus.req[idx] || wd_fire) begin
                        gnt_q <= 3'b000;
                        state <= DRAIN;
`ifdef MODE_ARB_TIMEOUT_EN
                        terr_q <= wd_fire && bus.req[idx];
`endif
                    end
                end

                // mode held one more cycle so the last beat clears the
                // registered mux path.
                DRAIN: begin
                    mode_q <= 2'd3;
                    busy_q <= 1'b0;
                    ptr    <= next_idx(idx);
                    state  <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.mode = mode_q;
    assign bus.gnt  = gnt_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_mode_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mode_arbiter
// Self-checking bench for mode_arbiter. A transaction-level reference model
// (round-robin pointer, expected winner, expected burst length) predicts each
// burst; randomized strobe/request patterns exercise it.
// ---------------------------------------------------------------------------
module tb_mode_arbiter;

    localparam int BL = 16;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   m_ptr = 0;
    int   last_fall = -1;

    mode_arbiter_if bus ();

    mode_arbiter #(.BURST_LEN(BL), .TIMEOUT(TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic int pick(input logic [2:0] r, input int p);
        for (int k = 0; k < 3; k++)
            if (r[(p + k) % 3]) return (p + k) % 3;
        return -1;
    endfunction

    // Runs one burst for request pattern r. pct: chance (%) of an own strobe
    // per GRANT cycle; drop_at: drop own req together with that strobe
    // (0 = never); foreign: random strobes on the other sources; abort_at:
    // return mid-grant after that many strobes (0 = run to the end).
    task automatic do_burst(input logic [2:0] r, input int pct, input int drop_at,
                            input bit foreign, input int abort_at);
        int         idx, k, idle, iter;
        bit         s, dropped, done, timed_out;
        logic [2:0] oh;
        idx = pick(r, m_ptr);
        oh  = 3'(1 << idx);
        bus.req   = r;
        bus.en_in = 3'b000;
        step();
        total++;
        if (bus.mode !== 2'(idx) || bus.busy !== 1'b1 || bus.gnt !== 3'b000) begin
            bad++;
            $display("FAIL switch: mode=%0d busy=%b gnt=%b want mode=%0d busy=1 gnt=000",
                     bus.mode, bus.busy, bus.gnt, idx);
        end
        step();
        total++;
        if (bus.gnt !== oh || bus.mode !== 2'(idx)) begin
            bad++;
            $display("FAIL grant: gnt=%b mode=%0d want gnt=%b mode=%0d", bus.gnt, bus.mode, oh, idx);
        end
        if (last_fall >= 0) begin
            total++;
            if (cyc - last_fall != 3) begin
                bad++;
                $display("FAIL gnt_gap: got %0d cycles want 3", cyc - last_fall);
            end
        end
        k = 0; idle = 0; iter = 0; done = 0; timed_out = 0;
        while (!done) begin
            s = ($urandom_range(99) < pct);
            bus.en_in = s ? oh : 3'b000;
            if (foreign) bus.en_in = bus.en_in | (3'($urandom) & ~oh);
            dropped = (drop_at > 0) && s && (k + 1 == drop_at);
            if (dropped) bus.req = r & ~oh;
            step();
            iter++;
            if (s) begin k++; idle = 0; end
            else idle++;
`ifdef MODE_ARB_TIMEOUT_EN
            timed_out = !s && idle == TO;
`endif
            done = (k == BL) || dropped || timed_out;
            total++;
            if (done) begin
                if (bus.gnt !== 3'b000 || bus.mode !== 2'(idx) || bus.busy !== 1'b1
                    || bus.timeout_err !== timed_out) begin
                    bad++;
                    $display("FAIL burst_end: gnt=%b mode=%0d busy=%b terr=%b want 000/%0d/1/%b (k=%0d)",
                             bus.gnt, bus.mode, bus.busy, bus.timeout_err, idx, timed_out, k);
                end
            end else if (bus.gnt !== oh || bus.mode !== 2'(idx) || bus.timeout_err !== 1'b0) begin
                bad++;
                $display("FAIL in_grant: gnt=%b mode=%0d terr=%b want %b/%0d/0 (k=%0d)",
                         bus.gnt, bus.mode, bus.timeout_err, oh, idx, k);
            end
            if (!done && abort_at > 0 && k == abort_at) return;
            if (iter > 1000) begin
                bad++;
                $display("FAIL burst_budget: no release after %0d cycles, want release", iter);
                done = 1;
            end
        end
        last_fall = cyc;
        bus.en_in = 3'b000;
        bus.req   = 3'b000;
        step();
        total++;
        if (bus.mode !== 2'd3 || bus.busy !== 1'b0 || bus.gnt !== 3'b000 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL drain_exit: mode=%0d busy=%b gnt=%b terr=%b want 3/0/000/0",
                     bus.mode, bus.busy, bus.gnt, bus.timeout_err);
        end
        m_ptr = (idx + 1) % 3;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 3'b000;
        bus.en_in = 3'b000;
        #1;
        total++;
        if (bus.mode !== 2'd3 || bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_vals: mode=%0d gnt=%b busy=%b terr=%b want 3/000/0/0",
                     bus.mode, bus.gnt, bus.busy, bus.timeout_err);
        end
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        last_fall = -1;
        step();
        total++;
        if (bus.mode !== 2'd3 || bus.busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: mode=%0d busy=%b want 3/0", bus.mode, bus.busy);
        end
    endtask

    task automatic test_round_robin();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (pick(3'b111, m_ptr) != i % 3) begin
                bad++;
                $display("FAIL rr_order: burst %0d predicted %0d want %0d", i, pick(3'b111, m_ptr), i % 3);
            end
            do_burst(3'b111, 100, 0, 0, 0);
        end
    endtask

    task automatic test_single_burst();
        do_burst(3'b010, 100, 0, 0, 0);
    endtask

    task automatic test_early_release();
        do_burst(3'b001, 100, 3, 0, 0);
        // ptr now points at source 2
        do_burst(3'b111, 100, 0, 0, 0);
    endtask

    task automatic test_foreign_strobes();
        do_burst(3'b010, 100, 0, 1, 0);
        do_burst(3'b100, 70, 0, 1, 0);
    endtask

    task automatic test_watchdog();
`ifdef MODE_ARB_TIMEOUT_EN
        do_burst(3'b001, 0, 0, 0, 0);
        do_burst(3'b010, 100, 0, 0, 0);
`else
        int idx;
        logic [2:0] oh;
        int held;
        idx = pick(3'b001, m_ptr);
        oh  = 3'(1 << idx);
        bus.req = 3'b001;
        bus.en_in = 3'b000;
        step();
        step();
        held = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.gnt === oh && bus.timeout_err === 1'b0) held++;
        end
        total++;
        if (held != 100) begin
            bad++;
            $display("FAIL no_watchdog: grant held %0d cycles want 100", held);
        end
        bus.req = 3'b000;
        step();
        total++;
        if (bus.gnt !== 3'b000) begin
            bad++;
            $display("FAIL req_release: gnt=%b want 000", bus.gnt);
        end
        step();
        m_ptr = (idx + 1) % 3;
        last_fall = -1;
`endif
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            logic [2:0] r;
            int pct, drop;
            r    = 3'($urandom_range(7, 1));
            pct  = $urandom_range(100, 40);
            drop = ($urandom_range(1) == 1) ? $urandom_range(BL, 1) : 0;
            do_burst(r, pct, drop, 1'($urandom_range(1)), 0);
        end
    endtask

    task automatic test_reset_mid_burst();
        do_burst(3'b001, 100, 0, 0, 0);        // leaves ptr at 1
        do_burst(3'b010, 100, 0, 0, 10);       // stop inside GRANT after 10 strobes
        rst = 1'b1;
        #1;
        total++;
        if (bus.mode !== 2'd3 || bus.gnt !== 3'b000 || bus.busy !== 1'b0 || bus.timeout_err !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset: mode=%0d gnt=%b busy=%b terr=%b want 3/000/0/0",
                     bus.mode, bus.gnt, bus.busy, bus.timeout_err);
        end
        bus.req = 3'b000;
        bus.en_in = 3'b000;
        @(negedge clk);
        rst = 1'b0;
        m_ptr = 0;
        last_fall = -1;
        step();
        do_burst(3'b111, 100, 0, 0, 0);        // ptr back at 0: source 1 wins
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_single_burst();
        test_early_release();
        test_foreign_strobes();
        test_watchdog();
        test_random();
        test_reset_mid_burst();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
